// File: rtl/led_pkg.sv
// Shared definitions for the RGB LED PWM bank: register selects, mode bits,
// and the helper used to size the LED index port.
package led_pkg;

    typedef enum logic [1:0] {
        SEL_RED   = 2'd0,
        SEL_GREEN = 2'd1,
        SEL_BLUE  = 2'd2,
        SEL_MODE  = 2'd3
    } wr_sel_e;

    localparam int MODE_BREATHE_BIT = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index ports stay at least one bit wide even for a single LED.
    function automatic int led_idx_width(input int num_leds);
        return (num_leds > 1) ? clog2(num_leds) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active duty/breathe registers, envelope scaling, comparator.
// Latency: output registered one cycle after pwm_cnt; active values load at frame_load.
// Backpressure: none; shadow inputs are sampled only on frame boundaries.
module pwm_channel
#(
    parameter int DUTY_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic                  enable,
    input  logic                  frame_load,
    input  logic [DUTY_WIDTH-1:0] shadow_duty,
    input  logic                  shadow_breathe,
    input  logic [DUTY_WIDTH-1:0] envelope,
    input  logic [DUTY_WIDTH-1:0] pwm_cnt,
    output logic                  pwm_out
);

    logic [DUTY_WIDTH-1:0]   active_duty;
    logic                    active_breathe;
    logic [2*DUTY_WIDTH-1:0] product;
    logic [DUTY_WIDTH-1:0]   eff_duty;

    always_comb begin
        product  = {{DUTY_WIDTH{1'b0}}, active_duty} * {{DUTY_WIDTH{1'b0}}, envelope};
        eff_duty = active_duty;
        if (active_breathe) begin
            eff_duty = product[2*DUTY_WIDTH-1:DUTY_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            active_duty    <= '0;
            active_breathe <= 1'b0;
            pwm_out        <= 1'b0;
        end else begin
            if (frame_load) begin
                active_duty    <= shadow_duty;
                active_breathe <= shadow_breathe;
            end
            pwm_out <= enable && (eff_duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/rgb_pwm_bank.sv
// N-LED RGB PWM bank: shadow registers behind a write port, shared timebase and breathing envelope.
// Latency: shadow updates the cycle after accept; duties take effect at the next frame boundary.
// Backpressure: wr_ready held high after reset; out-of-range writes are dropped with a wr_err pulse.
module rgb_pwm_bank
    import led_pkg::*;
#(
    parameter int  NUM_LEDS   = 4,
    parameter int  DUTY_WIDTH = 8,
    parameter int  PRESCALE   = 390,
    localparam int LED_W      = led_idx_width(NUM_LEDS)
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [LED_W-1:0]      wr_led,
    input  logic [1:0]            wr_sel,
    input  logic [DUTY_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    output logic                  frame_start,
    output logic [NUM_LEDS-1:0]   red,
    output logic [NUM_LEDS-1:0]   green,
    output logic [NUM_LEDS-1:0]   blue
);

    localparam int PS_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

    logic [PS_W-1:0]       prescaler;
    logic [DUTY_WIDTH-1:0] pwm_cnt;
    logic [DUTY_WIDTH-1:0] envelope;
    logic                  env_up;
    logic                  tick;
    logic                  frame_wrap;
    logic                  wr_fire;
    logic                  wr_in_range;
    wr_sel_e               sel;

    logic [DUTY_WIDTH-1:0] shadow_red   [NUM_LEDS];
    logic [DUTY_WIDTH-1:0] shadow_green [NUM_LEDS];
    logic [DUTY_WIDTH-1:0] shadow_blue  [NUM_LEDS];
    logic [NUM_LEDS-1:0]   shadow_breathe;

    assign tick        = (prescaler == PS_W'(PRESCALE - 1));
    assign frame_wrap  = tick && (pwm_cnt == '1);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (32'(wr_led) < NUM_LEDS);
    assign sel         = wr_sel_e'(wr_sel);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            prescaler   <= '0;
            pwm_cnt     <= '0;
            envelope    <= '0;
            env_up      <= 1'b1;
            frame_start <= 1'b0;
            wr_ready    <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            wr_ready    <= 1'b1;
            wr_err      <= wr_fire && !wr_in_range;
            frame_start <= frame_wrap;
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            // Triangle envelope: flipping direction costs a step, so each endpoint spans two frames.
            if (frame_wrap) begin
                if (env_up) begin
                    if (envelope == '1) env_up   <= 1'b0;
                    else                envelope <= envelope + 1'b1;
                end else begin
                    if (envelope == '0) env_up   <= 1'b1;
                    else                envelope <= envelope - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            shadow_breathe <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow_red[i]   <= '0;
                shadow_green[i] <= '0;
                shadow_blue[i]  <= '0;
            end
        end else if (wr_fire && wr_in_range) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_led == LED_W'(i)) begin
                    case (sel)
                        SEL_RED:   shadow_red[i]     <= wr_data;
                        SEL_GREEN: shadow_green[i]   <= wr_data;
                        SEL_BLUE:  shadow_blue[i]    <= wr_data;
                        SEL_MODE:  shadow_breathe[i] <= wr_data[MODE_BREATHE_BIT];
                        default:   ;
                    endcase
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH)) u_red (
            .clock          (clock),
            .reset_         (reset_),
            .enable         (enable),
            .frame_load     (frame_wrap),
            .shadow_duty    (shadow_red[i]),
            .shadow_breathe (shadow_breathe[i]),
            .envelope       (envelope),
            .pwm_cnt        (pwm_cnt),
            .pwm_out        (red[i])
        );
        pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH)) u_green (
            .clock          (clock),
            .reset_         (reset_),
            .enable         (enable),
            .frame_load     (frame_wrap),
            .shadow_duty    (shadow_green[i]),
            .shadow_breathe (shadow_breathe[i]),
            .envelope       (envelope),
            .pwm_cnt        (pwm_cnt),
            .pwm_out        (green[i])
        );
        pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH)) u_blue (
            .clock          (clock),
            .reset_         (reset_),
            .enable         (enable),
            .frame_load     (frame_wrap),
            .shadow_duty    (shadow_blue[i]),
            .shadow_breathe (shadow_breathe[i]),
            .envelope       (envelope),
            .pwm_cnt        (pwm_cnt),
            .pwm_out        (blue[i])
        );
    end

endmodule
